// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory request/response types and arbiter state encoding
// Purpose: cache <-> main-memory transaction types used by mem_arbiter and its neighbours.
//   mem_req_type  : {addr, data, rw, valid}  request from a cache (or to memory)
//   mem_data_type : {data, ready}            response to a cache (or from memory)
//   arb_state_e   : arbiter FSM states
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-cache and D-cache requests onto one main-memory port
// Purpose: one transaction in flight; round-robin or fixed D-priority on simultaneous requests.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   i_req_i / d_req_i      cache requests {addr, data, rw, valid}
//   i_data_o / d_data_o    cache responses {data (broadcast), ready (granted side only)}
//   mem_req_o              request to memory, fields held from the grant-time sample
//   mem_data_i             memory response, ready is a one-cycle pulse
//   busy_o                 FSM not idle
//   gnt_d_o                current/last grant went to the D-cache
//   no_i_gnt_o/no_d_gnt_o  wrapping grant counters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit D_PRIORITY = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mem_req_type  i_req_i,
  input  mem_req_type  d_req_i,
  output mem_data_type i_data_o,
  output mem_data_type d_data_o,
  output mem_req_type  mem_req_o,
  input  mem_data_type mem_data_i,
  output logic         busy_o,
  output logic         gnt_d_o,
  output logic [CNT_W-1:0] no_i_gnt_o,
  output logic [CNT_W-1:0] no_d_gnt_o
);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_rw;
  logic              r_last_d;
  logic [CNT_W-1:0]  r_cnt_i;
  logic [CNT_W-1:0]  r_cnt_d;

  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_mem_valid;
  logic w_i_ready;
  logic w_d_ready;

  // D wins when alone, when it has fixed priority, or when I was served last.
  assign w_pick_d = d_req_i.valid && (!i_req_i.valid || D_PRIORITY || !r_last_d);

  always_comb begin
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_mem_valid  = 1'b0;
    w_i_ready    = 1'b0;
    w_d_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d    = 1'b1;
          w_next_state = GNT_D;
        end else if (i_req_i.valid) begin
          w_grant_i    = 1'b1;
          w_next_state = GNT_I;
        end
      end
      GNT_I: begin
        w_mem_valid = 1'b1;
        w_i_ready   = mem_data_i.ready;
        // A requester dropping valid before memory answers aborts the transaction.
        if (mem_data_i.ready || !i_req_i.valid) begin
          w_next_state = RELEASE;
        end
      end
      GNT_D: begin
        w_mem_valid = 1'b1;
        w_d_ready   = mem_data_i.ready;
        if (mem_data_i.ready || !d_req_i.valid) begin
          w_next_state = RELEASE;
        end
      end
      RELEASE: begin
        // One dead cycle lets the served cache drop valid before re-arbitration.
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_rw     <= 1'b0;
      r_last_d <= 1'b0;
      r_cnt_i  <= '0;
      r_cnt_d  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_d) begin
        r_addr   <= d_req_i.addr;
        r_data   <= d_req_i.data;
        r_rw     <= d_req_i.rw;
        r_last_d <= 1'b1;
        r_cnt_d  <= r_cnt_d + 1'b1;
      end else if (w_grant_i) begin
        r_addr   <= i_req_i.addr;
        r_data   <= i_req_i.data;
        r_rw     <= i_req_i.rw;
        r_last_d <= 1'b0;
        r_cnt_i  <= r_cnt_i + 1'b1;
      end
    end
  end

  assign mem_req_o.addr  = r_addr;
  assign mem_req_o.data  = r_data;
  assign mem_req_o.rw    = r_rw;
  assign mem_req_o.valid = w_mem_valid;

  assign i_data_o.data  = mem_data_i.data;
  assign i_data_o.ready = w_i_ready;
  assign d_data_o.data  = mem_data_i.data;
  assign d_data_o.ready = w_d_ready;

  assign busy_o     = (r_state != IDLE);
  assign gnt_d_o    = r_last_d;
  assign no_i_gnt_o = r_cnt_i;
  assign no_d_gnt_o = r_cnt_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam bit P_DPRI = 1'b0;
  localparam int P_CW   = 3;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
  } exp_mem_t;

  typedef struct {
    bit                side_d;
    logic [DATA_W-1:0] data;
  } exp_rsp_t;

  typedef struct {
    int                lat;
    logic [DATA_W-1:0] data;
  } plan_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  mem_req_type  i_req, d_req, mem_req;
  mem_data_type i_data, d_data, mem_data;
  logic         busy, gnt_d;
  logic [P_CW-1:0] n_i, n_d;

  mem_arbiter #(.D_PRIORITY(P_DPRI), .CNT_W(P_CW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .i_req_i    (i_req),
    .d_req_i    (d_req),
    .i_data_o   (i_data),
    .d_data_o   (d_data),
    .mem_req_o  (mem_req),
    .mem_data_i (mem_data),
    .busy_o     (busy),
    .gnt_d_o    (gnt_d),
    .no_i_gnt_o (n_i),
    .no_d_gnt_o (n_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  exp_mem_t exp_mem_q[$];
  exp_rsp_t exp_rsp_q[$];
  plan_t    plan_q[$];
  int       resp_busy = 0;

  // reference model state
  int m_cnt_i = 0;
  int m_cnt_d = 0;
  bit m_last_d = 1'b0;

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic mem_req_type rand_req();
    mem_req_type r;
    r.addr  = $urandom;
    r.data  = {$urandom, $urandom, $urandom, $urandom};
    r.rw    = 1'($urandom_range(0, 1));
    r.valid = 1'b0;
    return r;
  endfunction

  // monitor / scoreboard
  exp_mem_t cur;
  bit       prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_data.ready || d_data.ready) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_ready", {i_data.ready, d_data.ready}, 0);
        end else begin
          exp_rsp_t r;
          r = exp_rsp_q.pop_front();
          check("ready_exclusive", i_data.ready & d_data.ready, 0);
          check("rsp_side_d", d_data.ready, r.side_d);
          check("rsp_data", r.side_d ? d_data.data : i_data.data, r.data);
          check("gnt_d_at_rsp", gnt_d, r.side_d);
        end
      end
      if (mem_req.valid) begin
        if (!prev_v) begin
          if (exp_mem_q.size() == 0) begin
            check("unexpected_grant", mem_req.valid, 0);
          end else begin
            cur = exp_mem_q.pop_front();
            check("grant_addr", mem_req.addr, cur.addr);
            check("grant_data", mem_req.data, cur.data);
            check("grant_rw", mem_req.rw, cur.rw);
          end
        end else begin
          check("hold_addr", mem_req.addr, cur.addr);
          check("hold_data", mem_req.data, cur.data);
          check("hold_rw", mem_req.rw, cur.rw);
        end
      end
      prev_v = mem_req.valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  // memory responder: one plan entry per observed grant
  initial begin
    bit rp;
    plan_t p;
    rp = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req.valid && !rp && plan_q.size() != 0) begin
        p = plan_q.pop_front();
        resp_busy = 1;
        repeat (p.lat) @(posedge clk);
        #1;
        mem_data.ready = 1'b1;
        mem_data.data  = p.data;
        @(posedge clk);
        #1;
        mem_data.ready = 1'b0;
        mem_data.data  = {$urandom, $urandom, $urandom, $urandom};
        resp_busy = 0;
        rp = 1'b0;
      end else begin
        rp = mem_req.valid;
      end
    end
  end

  task automatic drop_valid(bit side);
    if (side) d_req.valid = 1'b0;
    else      i_req.valid = 1'b0;
  endtask

  task automatic serve(bit side, bit abort, bit toggle);
    if (abort) begin
      @(posedge clk);
      @(posedge clk);
      #1 drop_valid(side);
    end else begin
      bit got;
      mem_req_type t;
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (side ? d_data.ready : i_data.ready) begin
          got = 1'b1;
          break;
        end
        // only after the grant edge; grant-time values must stick
        if (toggle && k >= 1) begin
          t = rand_req();
          t.valid = 1'b1;
          if (side) d_req = t;
          else      i_req = t;
        end
      end
      check(side ? "d_ready_seen" : "i_ready_seen", got, 1);
      @(posedge clk);
      #1 drop_valid(side);
    end
  endtask

  task automatic settle_and_check();
    for (int k = 0; k < 60 && resp_busy != 0; k++) @(posedge clk);
    check("responder_done", resp_busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cnt_i", n_i, m_cnt_i);
    check("cnt_d", n_d, m_cnt_d);
    check("busy_idle", busy, 0);
    check("mem_valid_idle", mem_req.valid, 0);
    check("exp_mem_drained", exp_mem_q.size(), 0);
    check("exp_rsp_drained", exp_rsp_q.size(), 0);
  endtask

  task automatic round(bit ri, bit rd, bit abort, bit toggle);
    mem_req_type ir, dr, w;
    bit order[$];
    plan_t p;
    exp_rsp_t r;
    ir = rand_req();
    dr = rand_req();
    if (ri && rd) begin
      if (P_DPRI || !m_last_d) order = '{1'b1, 1'b0};
      else                     order = '{1'b0, 1'b1};
    end else if (rd) order = '{1'b1};
    else             order = '{1'b0};
    foreach (order[k]) begin
      w = order[k] ? dr : ir;
      exp_mem_q.push_back('{addr: w.addr, data: w.data, rw: w.rw});
      m_last_d = order[k];
      if (order[k]) m_cnt_d = (m_cnt_d + 1) % (1 << P_CW);
      else          m_cnt_i = (m_cnt_i + 1) % (1 << P_CW);
      p.data = {$urandom, $urandom, $urandom, $urandom};
      p.lat  = abort ? $urandom_range(2, 5) : $urandom_range(1, 6);
      plan_q.push_back(p);
      if (!abort) begin
        r.side_d = order[k];
        r.data   = p.data;
        exp_rsp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    i_req = ir; i_req.valid = ri;
    d_req = dr; d_req.valid = rd;
    fork
      begin if (ri) serve(1'b0, abort, toggle); end
      begin if (rd) serve(1'b1, abort, toggle); end
    join
    settle_and_check();
  endtask

  task automatic reset_mid_grant();
    plan_t p;
    mem_req_type dr;
    dr = rand_req();
    exp_mem_q.push_back('{addr: dr.addr, data: dr.data, rw: dr.rw});
    p.lat  = 6;
    p.data = {$urandom, $urandom, $urandom, $urandom};
    plan_q.push_back(p);
    @(posedge clk);
    #1;
    d_req = dr; d_req.valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_valid", mem_req.valid, 0);
    check("rst_mem_addr", mem_req.addr, 0);
    check("rst_d_ready", d_data.ready, 0);
    check("rst_i_ready", i_data.ready, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_d", gnt_d, 0);
    check("rst_cnt_i", n_i, 0);
    check("rst_cnt_d", n_d, 0);
    m_cnt_i = 0;
    m_cnt_d = 0;
    m_last_d = 1'b0;
    d_req.valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle_and_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ri, rd, ab;
    i_req = '0;
    d_req = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("inreset_mem_valid", mem_req.valid, 0);
    check("inreset_busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_mem_valid", mem_req.valid, 0);
    check("idle_busy", busy, 0);
    check("idle_cnt_i", n_i, 0);
    check("idle_cnt_d", n_d, 0);
    check("idle_gnt_d", gnt_d, 0);
    check("idle_readies", {i_data.ready, d_data.ready}, 0);

    round(1'b0, 1'b1, 1'b0, 1'b0);          // D alone
    repeat (3) round(1'b1, 1'b1, 1'b0, 1'b0); // simultaneous pairs
    round(1'b0, 1'b1, 1'b0, 1'b1);          // D with toggling inputs during grant
    round(1'b1, 1'b0, 1'b1, 1'b0);          // I aborted
    round(1'b0, 1'b1, 1'b0, 1'b0);          // D afterwards served normally
    reset_mid_grant();
    round(1'b1, 1'b1, 1'b0, 1'b0);          // tie after reset: last_d back to 0

    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      ri = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      ab = (ri ^ rd) && ($urandom_range(0, 4) == 0);
      round(ri, rd, ab, (ri ^ rd) && !ab && 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
